fmap_stream_tx: RTL and testbench

//   Frame-buffer transmitter for the 4-channel pixel stream consumed by the pool/ReLU stage.
//   The loader writes one W x H feature map (4 channels in parallel) into internal RAM.
//   On iStart the block replays the map in row-major order, one pixel per cycle, on the

---
 rtl/fmap_stream_tx.sv | 149 ++++++++++++++
 tb/tb_fmap_stream_tx.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmap_stream_tx.sv
// Frame-buffer transmitter: loads a W x H four-channel map, then replays it row-major.
// Optional macro FMAP_TX_ROW_GAP_EN inserts one bubble cycle after every row except the last.
module fmap_stream_tx #(
  parameter int unsigned In_d_W = 32,
  parameter int unsigned W      = 26,
  parameter int unsigned H      = 28,
  localparam int unsigned ADDR_W = $clog2(W * H)
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iWrEn,
  input  logic [ADDR_W-1:0] iWrAddr,
  input  logic [In_d_W-1:0] iWrData0,
  input  logic [In_d_W-1:0] iWrData1,
  input  logic [In_d_W-1:0] iWrData2,
  input  logic [In_d_W-1:0] iWrData3,
  input  logic              iStart,
  input  logic [3:0]        iChMask,
  input  logic              iHold,
  output logic              oBusy,
  output logic              oDone,
  output logic [3:0]        oValid4,
  output logic [In_d_W-1:0] oData0,
  output logic [In_d_W-1:0] oData1,
  output logic [In_d_W-1:0] oData2,
  output logic [In_d_W-1:0] oData3
);

  localparam int unsigned       NPIX      = W * H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W:0]   NPIX_W    = (ADDR_W + 1)'(NPIX);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e r_state;
  state_e w_state_nxt;

  logic [3:0][In_d_W-1:0] r_mem [NPIX];
  logic [3:0][In_d_W-1:0] r_rd_data;
  logic [3:0][In_d_W-1:0] r_data;
  logic                   r_rd_vld;
  logic [ADDR_W-1:0]      r_addr;
  logic [3:0]             r_mask;
  logic [3:0]             r_valid4;

  logic w_busy;
  logic w_start;
  logic w_wr_ok;
  logic w_issue;
  logic w_last_issue;

  always_comb begin
    w_busy       = (r_state == StRun) || (r_state == StDrain);
    w_start      = (r_state == StIdle) && iStart;
    w_wr_ok      = iWrEn && !w_busy && ({1'b0, iWrAddr} < NPIX_W);
    w_last_issue = w_issue && (r_addr == LAST_ADDR);
  end

`ifdef FMAP_TX_ROW_GAP_EN
  localparam int unsigned      COL_W    = (W > 1) ? $clog2(W) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(W - 1);

  logic [COL_W-1:0] r_col;
  logic             r_gap;

  always_comb begin
    w_issue = (r_state == StRun) && !iHold && !r_gap;
  end

  // r_gap marks the forced bubble owed after a row end; any non-issuing RUN cycle pays it.
  always_ff @(posedge iClk) begin
    if (iRst || w_start) begin
      r_col <= '0;
      r_gap <= 1'b0;
    end else if (w_issue) begin
      r_col <= (r_col == LAST_COL) ? '0 : r_col + 1'b1;
      r_gap <= (r_col == LAST_COL) && !w_last_issue;
    end else if (r_state == StRun) begin
      r_gap <= 1'b0;
    end
  end
`else
  always_comb begin
    w_issue = (r_state == StRun) && !iHold;
  end
`endif

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (iStart) w_state_nxt = StRun;
      StRun:   if (w_last_issue) w_state_nxt = StDrain;
      StDrain: if (!r_rd_vld) w_state_nxt = StDone;
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    oBusy   = w_busy;
    oDone   = (r_state == StDone);
    oValid4 = r_valid4;
    oData0  = r_data[0];
    oData1  = r_data[1];
    oData2  = r_data[2];
    oData3  = r_data[3];
  end

  // Read-before-write: a same-edge write to the read address returns the old word.
  always_ff @(posedge iClk) begin
    if (w_wr_ok) begin
      r_mem[iWrAddr] <= {iWrData3, iWrData2, iWrData1, iWrData0};
    end
    if (w_issue) begin
      r_rd_data <= r_mem[r_addr];
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_addr   <= '0;
      r_rd_vld <= 1'b0;
      r_mask   <= 4'b0;
      r_valid4 <= 4'b0;
      r_data   <= '0;
    end else begin
      r_rd_vld <= w_issue;
      if (w_start) begin
        r_mask <= iChMask;
        r_addr <= '0;
      end else if (w_issue) begin
        r_addr <= w_last_issue ? '0 : r_addr + 1'b1;
      end
      r_valid4 <= r_rd_vld ? r_mask : 4'b0;
      for (int c = 0; c < 4; c++) begin
        r_data[c] <= (r_rd_vld && r_mask[c]) ? r_rd_data[c] : '0;
      end
    end
  end

endmodule

// File: tb/tb_fmap_stream_tx.sv
// Directed bench for fmap_stream_tx: ramp frames, holds, masks, blocked writes, mid-frame reset.
module tb_fmap_stream_tx;

  localparam int unsigned DW   = 32;
  localparam int unsigned MW   = 26;
  localparam int unsigned MH   = 28;
  localparam int unsigned AW   = $clog2(MW * MH);
  localparam int          NPIX = MW * MH;
`ifdef FMAP_TX_ROW_GAP_EN
  localparam int G = 1;
`else
  localparam int G = 0;
`endif

  logic          clk = 1'b0;
  logic          iRst, iWrEn, iStart, iHold;
  logic [AW-1:0] iWrAddr;
  logic [DW-1:0] iWrData0, iWrData1, iWrData2, iWrData3;
  logic [3:0]    iChMask;
  logic          oBusy, oDone;
  logic [3:0]    oValid4;
  logic [DW-1:0] oData0, oData1, oData2, oData3;

  int tests_run    = 0;
  int tests_failed = 0;

  fmap_stream_tx #(.In_d_W(DW), .W(MW), .H(MH)) dut (
    .iClk(clk), .iRst(iRst), .iWrEn(iWrEn), .iWrAddr(iWrAddr),
    .iWrData0(iWrData0), .iWrData1(iWrData1), .iWrData2(iWrData2), .iWrData3(iWrData3),
    .iStart(iStart), .iChMask(iChMask), .iHold(iHold),
    .oBusy(oBusy), .oDone(oDone), .oValid4(oValid4),
    .oData0(oData0), .oData1(oData1), .oData2(oData2), .oData3(oData3)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [3:0]    v;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic [DW-1:0] d3;
  } px_t;

  px_t  cap[$];
  int   cap_first, cap_done, cap_done_cnt, cap_busy_fall, cap_bubbles;
  logic cap_rst_ok;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] exp_d(input int i, input int c, input logic [3:0] mask);
    return mask[c] ? DW'(i * 4 + c) : '0;
  endfunction

  // Index of the first captured pixel that differs from the ramp under mask, else -1.
  function automatic int stream_bad(input logic [3:0] mask);
    for (int i = 0; i < cap.size(); i++) begin
      if (cap[i].v !== mask || cap[i].d0 !== exp_d(i, 0, mask) || cap[i].d1 !== exp_d(i, 1, mask)
          || cap[i].d2 !== exp_d(i, 2, mask) || cap[i].d3 !== exp_d(i, 3, mask)) return i;
    end
    return -1;
  endfunction

  task automatic load_ramp();
    for (int n = 0; n < NPIX; n++) begin
      iWrEn = 1'b1; iWrAddr = AW'(n);
      iWrData0 = DW'(n * 4); iWrData1 = DW'(n * 4 + 1);
      iWrData2 = DW'(n * 4 + 2); iWrData3 = DW'(n * 4 + 3);
      tick();
    end
    iWrEn = 1'b0;
  endtask

  // Starts a frame (edge k) and samples after every following edge k+c.
  task automatic run_frame(input logic [3:0] mask, input int hold_at, input int hold_len,
                           input int wr_at, input int strt_at, input int rst_at, input int budget);
    int stop;
    cap.delete();
    cap_first = -1; cap_done = -1; cap_done_cnt = 0; cap_busy_fall = -1; cap_bubbles = 0;
    cap_rst_ok = 1'b0;
    iChMask = mask; iStart = 1'b1;
    tick();
    iStart = 1'b0; iChMask = 4'h0; iWrEn = 1'b0;
    stop = budget;
    for (int c = 1; c <= stop; c++) begin
      tick();
      iHold = 1'b0; iWrEn = 1'b0; iStart = 1'b0; iRst = 1'b0;
      if (oValid4 != 4'h0) begin
        cap.push_back('{oValid4, oData0, oData1, oData2, oData3});
        if (cap_first < 0) cap_first = c;
      end else if (cap_first >= 0 && oBusy) begin
        cap_bubbles++;
      end
      if (oDone) begin
        cap_done_cnt++;
        if (cap_done < 0) begin
          cap_done = c;
          stop = c + 1;
        end
      end
      if (!oBusy && cap_busy_fall < 0) cap_busy_fall = c;
      if (c == rst_at + 1)
        cap_rst_ok = (oValid4 == 4'h0) && (oData0 == '0) && (oData1 == '0) && (oData2 == '0)
                     && (oData3 == '0) && !oBusy && !oDone;
      if (c >= hold_at && c < hold_at + hold_len) iHold = 1'b1;
      if (c == wr_at) begin
        iWrEn = 1'b1; iWrAddr = '0;
        iWrData0 = '1; iWrData1 = '1; iWrData2 = '1; iWrData3 = '1;
      end
      if (c == strt_at) iStart = 1'b1;
      if (c == rst_at) iRst = 1'b1;
    end
    iHold = 1'b0; iWrEn = 1'b0; iStart = 1'b0; iRst = 1'b0;
  endtask

  task automatic test_reset();
    iRst = 1'b1; iWrEn = 1'b0; iStart = 1'b0; iHold = 1'b0; iChMask = 4'h0;
    iWrAddr = '0; iWrData0 = '0; iWrData1 = '0; iWrData2 = '0; iWrData3 = '0;
    repeat (3) tick();
    tests_run++;
    if (oValid4 !== 4'h0) begin
      tests_failed++; $display("FAIL reset_valid: got %b, expected 0000", oValid4);
    end
    tests_run++;
    if ((oData0 | oData1 | oData2 | oData3) !== '0) begin
      tests_failed++; $display("FAIL reset_data: got %h %h %h %h, expected 0", oData0, oData1,
                               oData2, oData3);
    end
    tests_run++;
    if (oBusy !== 1'b0 || oDone !== 1'b0) begin
      tests_failed++; $display("FAIL reset_busy_done: got %b%b, expected 00", oBusy, oDone);
    end
    iRst = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    int bad;
    run_frame(4'hF, -1, 0, -1, -1, -1, 800);
    tests_run++;
    if (cap.size() !== NPIX) begin
      tests_failed++; $display("FAIL stream_count: got %0d, expected %0d", cap.size(), NPIX);
    end
    bad = stream_bad(4'hF);
    tests_run++;
    if (bad !== -1) begin
      tests_failed++; $display("FAIL stream_data: pixel %0d got d0=%0d, expected %0d", bad,
                               cap[bad].d0, bad * 4);
    end
    tests_run++;
    if (cap_first !== 2) begin
      tests_failed++; $display("FAIL stream_latency: got %0d, expected 2", cap_first);
    end
    tests_run++;
    if (cap_done !== 2 + NPIX + G * (MH - 1)) begin
      tests_failed++; $display("FAIL stream_done: got %0d, expected %0d", cap_done,
                               2 + NPIX + G * (MH - 1));
    end
    tests_run++;
    if (cap_done_cnt !== 1) begin
      tests_failed++; $display("FAIL stream_done_pulse: got %0d, expected 1", cap_done_cnt);
    end
    tests_run++;
    if (cap_busy_fall !== cap_done) begin
      tests_failed++; $display("FAIL stream_busy_fall: got %0d, expected %0d", cap_busy_fall,
                               cap_done);
    end
    tests_run++;
    if (cap_bubbles !== G * (MH - 1)) begin
      tests_failed++; $display("FAIL stream_bubbles: got %0d, expected %0d", cap_bubbles,
                               G * (MH - 1));
    end
  endtask

  task automatic test_hold();
    int bad;
    run_frame(4'hF, 140 + 5 * G, 3, -1, -1, -1, 800);
    tests_run++;
    if (cap.size() !== NPIX) begin
      tests_failed++; $display("FAIL hold_count: got %0d, expected %0d", cap.size(), NPIX);
    end
    bad = stream_bad(4'hF);
    tests_run++;
    if (bad !== -1) begin
      tests_failed++; $display("FAIL hold_data: pixel %0d got d0=%0d, expected %0d", bad,
                               cap[bad].d0, bad * 4);
    end
    tests_run++;
    if (cap_bubbles !== 3 + G * (MH - 1)) begin
      tests_failed++; $display("FAIL hold_bubbles: got %0d, expected %0d", cap_bubbles,
                               3 + G * (MH - 1));
    end
    tests_run++;
    if (cap_done !== 5 + NPIX + G * (MH - 1)) begin
      tests_failed++; $display("FAIL hold_done: got %0d, expected %0d", cap_done,
                               5 + NPIX + G * (MH - 1));
    end
  endtask

  task automatic test_mask();
    int bad;
    run_frame(4'b0101, -1, 0, -1, -1, -1, 800);
    tests_run++;
    if (cap.size() !== NPIX) begin
      tests_failed++; $display("FAIL mask_count: got %0d, expected %0d", cap.size(), NPIX);
    end
    bad = stream_bad(4'b0101);
    tests_run++;
    if (bad !== -1) begin
      tests_failed++; $display("FAIL mask_data: pixel %0d got v=%b d1=%0d, expected v=0101 d1=0",
                               bad, cap[bad].v, cap[bad].d1);
    end
    run_frame(4'b0000, -1, 0, -1, -1, -1, 800);
    tests_run++;
    if (cap.size() !== 0) begin
      tests_failed++; $display("FAIL mask0_count: got %0d, expected 0", cap.size());
    end
    tests_run++;
    if (cap_done !== 2 + NPIX + G * (MH - 1) || cap_done_cnt !== 1) begin
      tests_failed++; $display("FAIL mask0_done: got cycle %0d count %0d, expected %0d count 1",
                               cap_done, cap_done_cnt, 2 + NPIX + G * (MH - 1));
    end
  endtask

  task automatic test_write_during_run();
    int bad;
    run_frame(4'hF, -1, 0, 10, 50, -1, 800);
    bad = stream_bad(4'hF);
    tests_run++;
    if (bad !== -1 || cap.size() !== NPIX) begin
      tests_failed++; $display("FAIL busy_write_stream: bad pixel %0d count %0d, expected -1 %0d",
                               bad, cap.size(), NPIX);
    end
    run_frame(4'hF, -1, 0, -1, -1, -1, 800);
    tests_run++;
    if (cap.size() == 0 || cap[0].d0 !== 32'd0) begin
      tests_failed++; $display("FAIL busy_write_pixel0: got %h, expected 0",
                               (cap.size() == 0) ? 32'hx : cap[0].d0);
    end
    bad = stream_bad(4'hF);
    tests_run++;
    if (bad !== -1) begin
      tests_failed++; $display("FAIL busy_write_frame2: pixel %0d got d0=%0d, expected %0d",
                               bad, cap[bad].d0, bad * 4);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    run_frame(4'hF, -1, 0, -1, -1, 302 + 11 * G, 340 + 11 * G);
    tests_run++;
    if (cap.size() !== 301 || cap[cap.size() - 1].d0 !== 32'd1200) begin
      tests_failed++; $display("FAIL rst_last_pixel: got count %0d, expected 301 ending d0=1200",
                               cap.size());
    end
    tests_run++;
    if (cap_rst_ok !== 1'b1) begin
      tests_failed++; $display("FAIL rst_outputs: got %b, expected 1", cap_rst_ok);
    end
    tests_run++;
    if (cap_done_cnt !== 0) begin
      tests_failed++; $display("FAIL rst_no_done: got %0d, expected 0", cap_done_cnt);
    end
    run_frame(4'hF, -1, 0, -1, -1, -1, 800);
    bad = stream_bad(4'hF);
    tests_run++;
    if (bad !== -1 || cap.size() !== NPIX || cap_done_cnt !== 1) begin
      tests_failed++; $display("FAIL rst_restart: bad %0d count %0d done %0d, expected -1 %0d 1",
                               bad, cap.size(), cap_done_cnt, NPIX);
    end
  endtask

  task automatic test_oob_write();
    int bad;
    iWrEn = 1'b1; iWrAddr = AW'(NPIX);
    iWrData0 = '1; iWrData1 = '1; iWrData2 = '1; iWrData3 = '1;
    tick();
    iWrAddr = AW'(1000);
    tick();
    iWrEn = 1'b0;
    run_frame(4'hF, -1, 0, -1, -1, -1, 800);
    bad = stream_bad(4'hF);
    tests_run++;
    if (bad !== -1 || cap.size() !== NPIX) begin
      tests_failed++; $display("FAIL oob_write: bad %0d count %0d, expected -1 %0d", bad,
                               cap.size(), NPIX);
    end
  endtask

  task automatic test_start_with_write();
    iWrEn = 1'b1; iWrAddr = AW'(5);
    iWrData0 = 32'hCAFE_0000; iWrData1 = 32'hCAFE_0001;
    iWrData2 = 32'hCAFE_0002; iWrData3 = 32'hCAFE_0003;
    run_frame(4'hF, -1, 0, -1, -1, -1, 800);
    tests_run++;
    if (cap.size() !== NPIX) begin
      tests_failed++; $display("FAIL startwr_count: got %0d, expected %0d", cap.size(), NPIX);
    end else begin
      tests_run++;
      if (cap[5].d0 !== 32'hCAFE_0000 || cap[5].d3 !== 32'hCAFE_0003) begin
        tests_failed++; $display("FAIL startwr_pixel5: got %h %h, expected cafe0000 cafe0003",
                                 cap[5].d0, cap[5].d3);
      end
      tests_run++;
      if (cap[4].d0 !== 32'd16 || cap[6].d2 !== 32'd26) begin
        tests_failed++; $display("FAIL startwr_neighbours: got %0d %0d, expected 16 26",
                                 cap[4].d0, cap[6].d2);
      end
    end
  endtask

  initial begin
    test_reset();
    load_ramp();
    test_stream();
    test_hold();
    test_mask();
    test_write_during_run();
    test_reset_mid();
    test_oob_write();
    test_start_with_write();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
